nibble_serializer_tx: RTL and testbench
=======================================

Name: nibble_serializer_tx

Overview:
Parallel-to-serial transmitter. It is the read/unload counterpart of the team's parallel load registers. It captures a WIDTH-bit word on a load handshake, then shifts it out one bit per accepted cycle under valid/ready flow control. An optional even-parity bit follows the data, and a one-cycle done pulse closes the frame. It sits between a datapath register and a serial link or bit-serial consumer.

Parameters:
- WIDTH, 4: data word width in bits (min 2).
- MSB_FIRST, 1: 1 = dataIn[WIDTH-1] sent first; 0 = dataIn[0] sent first.
- PARITY_EN, 1: 1 = append an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  reset, synchronous, active-high.
- ld  in  1  parallel load request; accepted only when ready=1.
- dataIn  in  WIDTH  word to transmit; sampled on the accepted ld edge.
- ready  out  1  1 = IDLE, able to accept ld.
- busy  out  1  1 = frame in progress (SHIFT, PARITY or DONE).
- serOut  out  1  current serial bit.
- serValid  out  1  serOut holds a bit for the consumer.
- serFirst  out  1  qualifies the first data bit of the frame.
- serLast  out  1  qualifies the final bit of the frame (parity bit if PARITY_EN=1, else last data bit).
- serReady  in  1  consumer accepts the bit when serValid & serReady at a clk edge.
- done  out  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Clock and reset: rst is evaluated only at the clk rising edge and has priority over all other inputs.
- Reset values: state=IDLE, shift register=0, bit counter=0, parity=0; ready=1, busy=0, serOut=0, serValid=0, serFirst=0, serLast=0, done=0.
- FSM states: IDLE, SHIFT, PARITY, DONE.
- IDLE:
  - ready=1, serValid=0, serOut=0.
  - On ld=1 at an edge: capture dataIn into the shift register, clear the bit counter, latch parity = XOR of dataIn, go to SHIFT.
- SHIFT:
  - serValid=1; serOut = shift register bit selected by MSB_FIRST; serFirst=1 only while bit counter=0.
  - On serValid & serReady: shift by one and increment the counter.
  - When the bit with counter=WIDTH-1 is accepted: go to PARITY if PARITY_EN=1, else go to DONE.
  - When PARITY_EN=0, serLast=1 during the counter=WIDTH-1 bit.
  - With serReady=0, serOut, serFirst, serLast and the counter hold unchanged.
- PARITY (PARITY_EN=1 only):
  - serValid=1, serOut = latched even-parity bit, serLast=1.
  - Go to DONE on accept; hold while serReady=0.
- DONE:
  - serValid=0, done=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency:
  - ld accepted at edge k → first bit valid in cycle k+1.
  - With serReady held at 1, a frame spans WIDTH+PARITY_EN cycles plus one DONE cycle; ready returns in cycle k+WIDTH+PARITY_EN+2.
- Boundary conditions:
  - ld while busy=1: ignored; dataIn is not sampled and the frame in flight is not corrupted.
  - ld and rst in the same edge: rst wins; nothing is captured.
  - rst mid-frame: the frame is abandoned and reset values appear in the next cycle; no done pulse is issued.
  - serReady=1 while serValid=0: no effect.
  - Counter: width clog2(WIDTH)+1; it never wraps within a frame.
- busy = ~ready at all times. serFirst and serLast are never asserted while serValid=0.

Decomposition:
- Shared package (nibble_ser_pkg):
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3.
  - Default WIDTH constant.
- One sub-module, piso_shift_reg (parameterised WIDTH, MSB_FIRST):
  - Synchronous load and shift-enable, with load having priority.
  - Serial output tap.
- The top level holds the FSM, counter, parity latch and handshake logic.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, PARITY_EN=1, serReady=1; ld with dataIn=4'hB → serOut 1,0,1,1, then parity 1. serFirst on bit 1, serLast on the parity cycle. done pulse in cycle 6 after the ld edge; ready=1 in cycle 7.
2. MSB_FIRST=0, PARITY_EN=0, dataIn=4'hB → serOut 1,1,0,1 with serLast on the 4th bit. done the following cycle; no parity cycle.
3. Backpressure: dataIn=4'h6, serReady=0 for 3 cycles while the 2nd bit is presented → serOut=1 held stable all 3 cycles, counter frozen, remaining bits 1,0 then parity 0, frame otherwise intact.
4. ld with dataIn=4'hF during SHIFT of a 4'h3 frame → ignored; output stays 0,0,1,1, parity 0, single done pulse.
5. rst asserted in the 3rd SHIFT cycle → next cycle all outputs at reset values, no done; a new ld with 4'h8 then sends 1,0,0,0, parity 1 cleanly.
6. Back-to-back: ld held high with 4'hA then 4'h5 → second word accepted exactly on the first IDLE edge after DONE; streams 1,0,1,0,p0 then 0,1,0,1,p0.

Source files
------------

// File: rtl/nibble_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_ser_pkg
// Purpose : Shared constants and FSM state type for the nibble serializer.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package nibble_ser_pkg;

  localparam int unsigned c_default_width = 4;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_shift  = 2'd1;
  localparam logic [1:0] c_st_parity = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = c_st_idle,
    SHIFT  = c_st_shift,
    PARITY = c_st_parity,
    DONE   = c_st_done
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_serializer_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serializer_tx_if
// Purpose : Load handshake and serial bit stream bundle of the serializer.
// Ports   : ld/dataIn/ready/busy  - parallel load side
//           serOut/serValid/serFirst/serLast/serReady - serial side
//           done - end-of-frame pulse
//           modport slave  : transmitter side
//           modport master : client side (loader + serial consumer)
// Rev     : 1.0  initial release
// ============================================================================
interface nibble_serializer_tx_if #(
  parameter int WIDTH = nibble_ser_pkg::c_default_width
) ();

  logic             ld;
  logic [WIDTH-1:0] dataIn;
  logic             ready;
  logic             busy;
  logic             serOut;
  logic             serValid;
  logic             serFirst;
  logic             serLast;
  logic             serReady;
  logic             done;

  modport slave (
    input  ld, dataIn, serReady,
    output ready, busy, serOut, serValid, serFirst, serLast, done
  );

  modport master (
    output ld, dataIn, serReady,
    input  ready, busy, serOut, serValid, serFirst, serLast, done
  );

endinterface
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : piso_shift_reg
// Purpose : Parallel-in serial-out shift register with a fixed output tap.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_load        - capture i_data (wins over i_shift)
//           i_shift       - advance one bit towards the tap
//           i_data[WIDTH] - parallel word
//           o_tap         - bit currently at the serial output position
// Rev     : 1.0  initial release
// ============================================================================
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic             i_shift,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_tap
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;

  // Zeros are shifted in behind the data so a drained register reads 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
      assign o_tap     = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
      assign o_tap     = r_sr[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= w_shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nibble_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serializer_tx
// Purpose : Captures a WIDTH-bit word on ld and streams it out one bit per
//           accepted cycle, optionally followed by an even-parity bit, then
//           pulses done for one cycle.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - nibble_serializer_tx_if.slave (load + serial handshake)
// Rev     : 1.0  initial release
// ============================================================================
module nibble_serializer_tx
  import nibble_ser_pkg::*;
#(
  parameter int WIDTH     = c_default_width,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input wire logic              clk,
  input wire logic              rst,
  nibble_serializer_tx_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_par;
  logic               r_ready;
  logic               r_busy;
  logic               r_valid;
  logic               r_first;
  logic               r_last;
  logic               r_done;

  logic w_load;
  logic w_shift;
  logic w_tap;
  logic w_last_data;
  logic w_next_last;

  assign w_load      = (r_state == IDLE)  && bus.ld;
  assign w_shift     = (r_state == SHIFT) && bus.serReady;
  assign w_last_data = (r_cnt == c_cnt_w'(WIDTH - 1));
  assign w_next_last = (r_cnt == c_cnt_w'(WIDTH - 2));

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (bus.dataIn),
    .o_tap   (w_tap)
  );

  // Handshake flags are registered alongside the state so they change only
  // on clock edges together with the bit they qualify.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.ld) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_par   <= ^bus.dataIn;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.serReady) begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_first <= 1'b0;
            if (w_last_data) begin
              if (PARITY_EN) begin
                r_state <= PARITY;
                r_last  <= 1'b1;
              end else begin
                r_state <= DONE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              // Without parity the last data bit closes the frame.
              r_last <= !PARITY_EN && w_next_last;
            end
          end
        end
        PARITY: begin
          if (bus.serReady) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.busy     = r_busy;
  assign bus.serValid = r_valid;
  assign bus.serFirst = r_first;
  assign bus.serLast  = r_last;
  assign bus.done     = r_done;
  assign bus.serOut   = (r_state == SHIFT)  ? w_tap :
                        (r_state == PARITY) ? r_par : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_serializer_tx
// Purpose : Scoreboard bench for nibble_serializer_tx. Instance A uses
//           MSB-first with parity, instance B LSB-first without parity.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_nibble_serializer_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct packed {
    logic is_done;
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  nibble_serializer_tx_if #(.WIDTH(4)) bus_a ();
  nibble_serializer_tx_if #(.WIDTH(4)) bus_b ();

  nibble_serializer_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  nibble_serializer_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bits[n-1] is the first bit on the wire; a complete frame flags its final
  // bit as last and is followed by a done pulse.
  task automatic push_bits(input int which, input logic [7:0] bits, input int n,
                           input bit complete);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.b       = bits[n-1-i];
      e.first   = (i == 0);
      e.last    = complete && (i == n - 1);
      if (which == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    if (complete) begin
      e = 4'b1000;
      if (which == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int which, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (which == 0) ok = bus_a.ready && (q_a.size() == 0);
      else            ok = bus_b.ready && (q_b.size() == 0);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_timeout: got frame still open expected idle within 40 cycles", name);
    end
  endtask

  // Monitors: compare every accepted bit and every done pulse to the queue.
  always @(negedge clk) begin
    if (!rst_a) begin
      chk("A_busy_inv", bus_a.busy, !bus_a.ready);
      chk("A_flag_inv", (bus_a.serFirst | bus_a.serLast) & !bus_a.serValid, 0);
      if (bus_a.serValid && bus_a.serReady) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL A_unexpected_bit: got serOut=%0b expected no bit", bus_a.serOut);
        end else begin
          e_a = q_a.pop_front();
          chk("A_bit", {1'b0, bus_a.serOut, bus_a.serFirst, bus_a.serLast}, e_a);
        end
      end
      if (bus_a.done) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL A_unexpected_done: got done=1 expected no done");
        end else begin
          e_a = q_a.pop_front();
          chk("A_done", 4'b1000, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      chk("B_busy_inv", bus_b.busy, !bus_b.ready);
      chk("B_flag_inv", (bus_b.serFirst | bus_b.serLast) & !bus_b.serValid, 0);
      if (bus_b.serValid && bus_b.serReady) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL B_unexpected_bit: got serOut=%0b expected no bit", bus_b.serOut);
        end else begin
          e_b = q_b.pop_front();
          chk("B_bit", {1'b0, bus_b.serOut, bus_b.serFirst, bus_b.serLast}, e_b);
        end
      end
      if (bus_b.done) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL B_unexpected_done: got done=1 expected no done");
        end else begin
          e_b = q_b.pop_front();
          chk("B_done", 4'b1000, e_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.ld = 1'b0; bus_a.dataIn = 4'h0; bus_a.serReady = 1'b1;
    bus_b.ld = 1'b0; bus_b.dataIn = 4'h0; bus_b.serReady = 1'b1;
    repeat (3) tick();
    // {ready,busy,serOut,serValid,serFirst,serLast,done}
    chk("A_reset", {bus_a.ready, bus_a.busy, bus_a.serOut, bus_a.serValid,
                    bus_a.serFirst, bus_a.serLast, bus_a.done}, 7'b1000000);
    chk("B_reset", {bus_b.ready, bus_b.busy, bus_b.serOut, bus_b.serValid,
                    bus_b.serFirst, bus_b.serLast, bus_b.done}, 7'b1000000);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // 1: 4'hB MSB first -> 1,0,1,1 parity 1
    push_bits(0, 8'b10111, 5, 1'b1);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'hB;
    tick();
    bus_a.ld = 1'b0;
    chk("T1_first_bit", {bus_a.serValid, bus_a.serOut, bus_a.serFirst}, 3'b111);
    repeat (5) tick();
    chk("T1_done_cycle6", {bus_a.done, bus_a.ready}, 2'b10);
    tick();
    chk("T1_ready_cycle7", {bus_a.done, bus_a.ready}, 2'b01);

    // 2: 4'hB LSB first, no parity -> 1,1,0,1
    push_bits(1, 8'b1101, 4, 1'b1);
    bus_b.ld = 1'b1; bus_b.dataIn = 4'hB;
    tick();
    bus_b.ld = 1'b0;
    repeat (4) tick();
    chk("T2_done_cycle5", {bus_b.done, bus_b.serValid}, 2'b10);
    tick();
    chk("T2_ready_cycle6", bus_b.ready, 1'b1);

    // 3: backpressure on the 2nd bit of 4'h6 -> 0,1,1,0 parity 0
    push_bits(0, 8'b01100, 5, 1'b1);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'h6;
    tick();
    bus_a.ld = 1'b0;
    tick();
    bus_a.serReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("T3_stall", {bus_a.serValid, bus_a.serOut, bus_a.serFirst, bus_a.serLast}, 4'b1100);
      tick();
    end
    bus_a.serReady = 1'b1;
    wait_idle(0, "T3");

    // 4: ld with 4'hF while 4'h3 is shifting -> 0,0,1,1 parity 0
    push_bits(0, 8'b00110, 5, 1'b1);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'h3;
    tick();
    bus_a.ld = 1'b0;
    tick();
    bus_a.ld = 1'b1; bus_a.dataIn = 4'hF;
    chk("T4_busy_no_ready", bus_a.ready, 1'b0);
    tick();
    tick();
    bus_a.ld = 1'b0;
    wait_idle(0, "T4");
    repeat (3) tick();
    chk("T4_stays_idle", {bus_a.ready, bus_a.serValid}, 2'b10);

    // 5: reset in the 3rd SHIFT cycle, with ld also high on that edge
    push_bits(0, 8'b10, 2, 1'b0);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'hB;
    tick();
    bus_a.ld = 1'b0;
    tick();
    tick();
    rst_a = 1'b1; bus_a.ld = 1'b1; bus_a.dataIn = 4'hF;
    tick();
    chk("T5_after_rst", {bus_a.ready, bus_a.busy, bus_a.serOut, bus_a.serValid,
                         bus_a.serFirst, bus_a.serLast, bus_a.done}, 7'b1000000);
    rst_a = 1'b0; bus_a.ld = 1'b0;
    tick();
    chk("T5_nothing_captured", {bus_a.ready, bus_a.serValid, bus_a.done}, 3'b100);
    chk("T5_partial_drained", q_a.size(), 0);
    push_bits(0, 8'b10001, 5, 1'b1);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'h8;
    tick();
    bus_a.ld = 1'b0;
    wait_idle(0, "T5");

    // 6: ld held high, 4'hA then 4'h5 back-to-back
    push_bits(0, 8'b10100, 5, 1'b1);
    push_bits(0, 8'b01010, 5, 1'b1);
    bus_a.ld = 1'b1; bus_a.dataIn = 4'hA;
    tick();
    bus_a.dataIn = 4'h5;
    repeat (5) tick();
    chk("T6_done_cycle6", bus_a.done, 1'b1);
    tick();
    chk("T6_ready_cycle7", bus_a.ready, 1'b1);
    tick();
    chk("T6_second_start", {bus_a.busy, bus_a.serFirst, bus_a.serOut}, 3'b110);
    bus_a.ld = 1'b0;
    wait_idle(0, "T6");

    repeat (2) tick();
    chk("A_queue_empty", q_a.size(), 0);
    chk("B_queue_empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
